// File: rtl/present_encryptor_param.sv
// present_encryptor_param: PRESENT-80/128 block cipher, UNROLL rounds per clock
module present_encryptor_param #(
    parameter int KEY_W  = 80,
    parameter int UNROLL = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [KEY_W-1:0] data_i,
    input  logic             key_load,
    input  logic             data_load,
    output logic [63:0]      data_o,
    output logic             valid_o,
    output logic             busy_o
);
    // nibble n of the S-box table is S(n)
    localparam logic [63:0] SBOX = 64'h21748FE3DA09B65C;
    // lowest key bit that receives the round counter
    localparam int CPOS = (KEY_W == 80) ? 15 : 62;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           fsm;
    logic [63:0]      st;
    logic [63:0]      nxt_st;
    logic [KEY_W-1:0] mkey;
    logic [KEY_W-1:0] wkey;
    logic [KEY_W-1:0] nxt_key;
    logic [4:0]       cnt;
    logic             last;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [63:0] round_f(input logic [63:0] s, input logic [63:0] k);
        logic [63:0] x;
        logic [63:0] p;
        x = s ^ k;
        for (int i = 0; i < 16; i++)
            x[4*i +: 4] = sbox(x[4*i +: 4]);
        for (int i = 0; i < 64; i++)
            p[(i == 63) ? 63 : (i * 16) % 63] = x[i];
        return p;
    endfunction

    function automatic logic [KEY_W-1:0] key_f(input logic [KEY_W-1:0] k, input logic [4:0] rc);
        logic [KEY_W-1:0] r;
        r = (k << 61) | (k >> (KEY_W - 61));
        r[KEY_W-1 -: 4] = sbox(r[KEY_W-1 -: 4]);
        if (KEY_W == 128)
            r[KEY_W-5 -: 4] = sbox(r[KEY_W-5 -: 4]);
        r[CPOS +: 5] = r[CPOS +: 5] ^ rc;
        return r;
    endfunction

    // this cycle's rounds; stages beyond round 31 pass their input through unchanged
    always_comb begin
        nxt_st  = st;
        nxt_key = wkey;
        for (int j = 0; j < UNROLL; j++)
            if ({1'b0, cnt} + 6'(j) <= 6'd31) begin
                nxt_st  = round_f(nxt_st, nxt_key[KEY_W-1 -: 64]);
                nxt_key = key_f(nxt_key, cnt + 5'(j));
            end
    end

    assign last = ({1'b0, cnt} + 6'(UNROLL)) >= 6'd32;

    // control FSM with datapath registers and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm     <= IDLE;
            st      <= '0;
            mkey    <= '0;
            wkey    <= '0;
            cnt     <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (key_load)
                        mkey <= data_i;
                    else if (data_load) begin
                        st     <= data_i[63:0];
                        wkey   <= mkey;
                        cnt    <= 5'd1;
                        busy_o <= 1'b1;
                        fsm    <= RUN;
                    end
                end
                RUN: begin
                    st   <= nxt_st;
                    wkey <= nxt_key;
                    if (last) begin
                        data_o  <= nxt_st ^ nxt_key[KEY_W-1 -: 64];
                        valid_o <= 1'b1;
                        busy_o  <= 1'b0;
                        fsm     <= IDLE;
                    end else
                        cnt <= cnt + 5'(UNROLL);
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_present_encryptor_param.sv
// tb_present_encryptor_param: five PRESENT configurations driven in parallel against a transaction-level model
module tb_present_encryptor_param;
    localparam int NI = 5;
    localparam int KWS [NI] = '{80, 80, 128, 80, 128};
    localparam int NS  [NI] = '{31, 8, 31, 4, 16};
    localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_load = 1'b0;
    logic         data_load = 1'b0;
    logic [127:0] data = '0;
    logic [63:0]  dout [NI];
    logic         vld  [NI];
    logic         bsy  [NI];

    logic [127:0] m_key  [NI];
    logic [63:0]  m_pend [NI];
    logic [63:0]  m_dout [NI];
    logic         m_vld  [NI];
    logic         m_busy [NI];
    int           m_cnt  [NI];
    int           lat    [NI];
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    present_encryptor_param #(.KEY_W(80), .UNROLL(1)) u0 (.clk_i(clk), .rst_i(rst), .data_i(data[79:0]),
        .key_load(key_load), .data_load(data_load), .data_o(dout[0]), .valid_o(vld[0]), .busy_o(bsy[0]));
    present_encryptor_param #(.KEY_W(80), .UNROLL(4)) u1 (.clk_i(clk), .rst_i(rst), .data_i(data[79:0]),
        .key_load(key_load), .data_load(data_load), .data_o(dout[1]), .valid_o(vld[1]), .busy_o(bsy[1]));
    present_encryptor_param #(.KEY_W(128), .UNROLL(1)) u2 (.clk_i(clk), .rst_i(rst), .data_i(data),
        .key_load(key_load), .data_load(data_load), .data_o(dout[2]), .valid_o(vld[2]), .busy_o(bsy[2]));
    present_encryptor_param #(.KEY_W(80), .UNROLL(8)) u3 (.clk_i(clk), .rst_i(rst), .data_i(data[79:0]),
        .key_load(key_load), .data_load(data_load), .data_o(dout[3]), .valid_o(vld[3]), .busy_o(bsy[3]));
    present_encryptor_param #(.KEY_W(128), .UNROLL(2)) u4 (.clk_i(clk), .rst_i(rst), .data_i(data),
        .key_load(key_load), .data_load(data_load), .data_o(dout[4]), .valid_o(vld[4]), .busy_o(bsy[4]));

    // reference cipher: whole block at once, key length selected by kw
    function automatic logic [63:0] present_enc(input logic [63:0] pt, input logic [127:0] key, input int kw);
        logic [63:0]  s;
        logic [63:0]  t;
        logic [127:0] k;
        logic [79:0]  k80;
        s = pt;
        k = key;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ ((kw == 80) ? k[79:16] : k[127:64]);
            for (int n = 0; n < 16; n++)
                s[4*n +: 4] = SB[s[4*n +: 4]];
            t = '0;
            for (int i = 0; i < 64; i++)
                t[16 * (i % 4) + i / 4] = s[i];
            s = t;
            if (kw == 80) begin
                k80 = k[79:0];
                k80 = {k80[18:0], k80[79:19]};
                k80[79:76] = SB[k80[79:76]];
                k80[19:15] = k80[19:15] ^ 5'(r);
                k = {48'b0, k80};
            end else begin
                k = {k[66:0], k[127:67]};
                k[127:124] = SB[k[127:124]];
                k[123:120] = SB[k[123:120]];
                k[66:62] = k[66:62] ^ 5'(r);
            end
        end
        return s ^ ((kw == 80) ? k[79:16] : k[127:64]);
    endfunction

    // transaction-level model: idle/busy with a latency countdown per configuration
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                m_key[i]  <= '0;
                m_pend[i] <= '0;
                m_dout[i] <= '0;
                m_vld[i]  <= 1'b0;
                m_busy[i] <= 1'b0;
                m_cnt[i]  <= 0;
            end else begin
                m_vld[i] <= 1'b0;
                if (m_busy[i]) begin
                    m_cnt[i] <= m_cnt[i] - 1;
                    if (m_cnt[i] == 1) begin
                        m_busy[i] <= 1'b0;
                        m_vld[i]  <= 1'b1;
                        m_dout[i] <= m_pend[i];
                    end
                end else if (key_load)
                    m_key[i] <= (KWS[i] == 80) ? {48'b0, data[79:0]} : data;
                else if (data_load) begin
                    m_pend[i] <= present_enc(data[63:0], m_key[i], KWS[i]);
                    m_busy[i] <= 1'b1;
                    m_cnt[i]  <= NS[i];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_key(input logic [127:0] k);
        @(negedge clk);
        data = k;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
    endtask

    // mode 0 plain, 1 loads mid-run, 2 reset at cycle 10, 3 back-to-back load in the valid cycle of u0
    task automatic run_block(input logic [63:0] pt, input int mode, input logic [63:0] pt2);
        for (int i = 0; i < NI; i++)
            lat[i] = -1;
        @(negedge clk);
        data = {$urandom, $urandom, pt};
        data_load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data_load = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++)
                if (vld[i] && lat[i] < 0)
                    lat[i] = c;
            if (mode == 1 && c == 1) begin
                key_load = 1'b1;
                data = {$urandom, $urandom, $urandom, $urandom};
            end
            if (mode == 1 && c == 2) begin
                key_load = 1'b0;
                data_load = 1'b1;
            end
            if (mode == 1 && c == 3)
                data_load = 1'b0;
            if (mode == 2 && c == 10) begin
                rst = 1'b1;
                #1;
                chk("abort data_o", {64'b0, dout[0]}, '0);
                chk("abort valid_o", {127'b0, vld[0]}, '0);
                chk("abort busy_o", {127'b0, bsy[0]}, '0);
                chk("abort busy_o u4", {127'b0, bsy[4]}, '0);
            end
            if (mode == 2 && c == 11)
                rst = 1'b0;
            if (mode == 3 && c == NS[0]) begin
                data = {$urandom, $urandom, pt2};
                data_load = 1'b1;
            end
            if (mode == 3 && c == NS[0] + 1) begin
                data_load = 1'b0;
                chk("b2b busy_o", {127'b0, bsy[0]}, 128'd1);
            end
        end
        if (mode == 2) begin
            chk("abort no valid u0", 128'(lat[0]), 128'(-1));
            chk("abort no valid u2", 128'(lat[2]), 128'(-1));
            chk("abort no valid u4", 128'(lat[4]), 128'(-1));
        end else
            for (int i = 0; i < NI; i++)
                chk($sformatf("latency u%0d", i), 128'(lat[i]), 128'(NS[i]));
    endtask

    initial begin
        logic [127:0] k;
        logic [63:0]  pt;
        logic [63:0]  pt2;
        logic         seen;
        // per-cycle comparison of every configuration against the model
        fork
            forever begin
                @(negedge clk);
                for (int i = 0; i < NI; i++) begin
                    total++;
                    if (dout[i] !== m_dout[i] || vld[i] !== m_vld[i] || bsy[i] !== m_busy[i]) begin
                        bad++;
                        $display("FAIL cycle u%0d: data_o=%h valid_o=%b busy_o=%b expected %h %b %b",
                                 i, dout[i], vld[i], bsy[i], m_dout[i], m_vld[i], m_busy[i]);
                    end
                end
            end
        join_none

        repeat (2) @(negedge clk);
        #1;
        chk("reset data_o", {64'b0, dout[0]}, '0);
        chk("reset valid_o", {127'b0, vld[0]}, '0);
        chk("reset busy_o", {127'b0, bsy[0]}, '0);
        chk("reset data_o u2", {64'b0, dout[2]}, '0);
        @(negedge clk);
        rst = 1'b0;

        chk("model 80 k0 p0", {64'b0, present_enc(64'h0, '0, 80)}, {64'b0, 64'h5579C1387B228445});
        chk("model 80 kF p0", {64'b0, present_enc(64'h0, '1, 80)}, {64'b0, 64'hE72C46C0F5945049});
        chk("model 80 k0 pF", {64'b0, present_enc('1, '0, 80)}, {64'b0, 64'hA112FFC72F68417B});
        chk("model 80 kF pF", {64'b0, present_enc('1, '1, 80)}, {64'b0, 64'h3333DCD3213210D2});
        chk("model 128 k0 p0", {64'b0, present_enc(64'h0, '0, 128)}, {64'b0, 64'h96DB702A2E6900AF});

        run_block(64'h0, 0, 64'h0);
        chk("zero key u0", {64'b0, dout[0]}, {64'b0, 64'h5579C1387B228445});
        chk("zero key u2", {64'b0, dout[2]}, {64'b0, 64'h96DB702A2E6900AF});

        pulse_key('1);
        run_block(64'h0, 0, 64'h0);
        chk("u4 kF p0", {64'b0, dout[1]}, {64'b0, 64'hE72C46C0F5945049});
        pulse_key('0);
        run_block('1, 0, 64'h0);
        chk("u4 k0 pF", {64'b0, dout[1]}, {64'b0, 64'hA112FFC72F68417B});
        pulse_key('1);
        run_block('1, 0, 64'h0);
        chk("u4 kF pF", {64'b0, dout[1]}, {64'b0, 64'h3333DCD3213210D2});

        k = {$urandom, $urandom, $urandom, $urandom};
        pt = {$urandom, $urandom};
        pt2 = {$urandom, $urandom};
        pulse_key(k);
        run_block(pt, 1, 64'h0);
        chk("mid-run loads u0", {64'b0, dout[0]}, {64'b0, present_enc(pt, k, 80)});
        chk("mid-run loads u2", {64'b0, dout[2]}, {64'b0, present_enc(pt, k, 128)});
        run_block(pt2, 0, 64'h0);
        chk("key persists u0", {64'b0, dout[0]}, {64'b0, present_enc(pt2, k, 80)});

        pulse_key('0);
        run_block({$urandom, $urandom}, 2, 64'h0);
        run_block(64'h0, 0, 64'h0);
        chk("after abort u0", {64'b0, dout[0]}, {64'b0, 64'h5579C1387B228445});

        k = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        data = k;
        key_load = 1'b1;
        data_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
        data_load = 1'b0;
        chk("both loads busy u0", {127'b0, bsy[0]}, '0);
        chk("both loads busy u1", {127'b0, bsy[1]}, '0);
        pt = {$urandom, $urandom};
        pt2 = {$urandom, $urandom};
        run_block(pt, 3, pt2);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(posedge clk);
            #1;
            seen = vld[0];
        end
        chk("b2b second valid", {127'b0, seen}, 128'd1);
        chk("b2b second data_o", {64'b0, dout[0]}, {64'b0, present_enc(pt2, k, 80)});

        repeat (6) begin
            if ($urandom_range(1) == 1)
                pulse_key({$urandom, $urandom, $urandom, $urandom});
            run_block({$urandom, $urandom}, 0, 64'h0);
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
